// File: rtl/mont_mul_unit.sv
// Radix-2 bit-serial Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// One iteration per cycle over WIDTH cycles, then one final-subtraction cycle.
module mont_mul_unit #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; done pulses for one cycle with
  // result valid in that cycle; busy covers every CALC and FIX cycle.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = WIDTH + 2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [PW-1:0]    b_ext, m_ext;
  logic [PW-1:0]    t_add, t_red, p_fix;

  assign b_ext = {2'b00, b_q};
  assign m_ext = {2'b00, m_q};

  // a_q is shifted right every iteration, so bit 0 is always the current a[i].
  assign t_add = p_q + (a_q[0] ? b_ext : '0);
  assign t_red = t_add + (t_add[0] ? m_ext : '0);
  assign p_fix = (p_q >= m_ext) ? (p_q - m_ext) : p_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        p_d   = {1'b0, t_red[PW-1:1]};
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = p_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign result    = res_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mont_mul_unit.sv
// Bench for mont_mul_unit: directed Montgomery cases, handshake corners,
// mid-operation reset and a randomized regression against a modular-arithmetic model.
module tb_mont_mul_unit;

  localparam int WIDTH   = 10;
  localparam int LAT     = WIDTH + 2;
  localparam int BUSY_N  = WIDTH + 1;
  localparam int MAX_CYC = 60;
  localparam int N_RAND  = 1500;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b, m;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  int total;
  int bad;

  // stimulus side-controls used inside run_mul
  bit poke_start;
  bit scramble;

  logic [31:0] exp_q[$];

  mont_mul_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .m         (m),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a*b mod m, then divide by 2 modulo m WIDTH times.
  function automatic logic [31:0] ref_mont(input int unsigned ra, input int unsigned rb,
                                           input int unsigned rm);
    longint unsigned x;
    x = (longint'(ra) * longint'(rb)) % rm;
    for (int k = 0; k < WIDTH; k++) begin
      if (x % 2 == 1) x = (x + rm) / 2;
      else            x = x / 2;
    end
    return 32'(x);
  endfunction

  // Drive one multiply from a negedge; report latency (clock periods from
  // the start-drive negedge to the negedge where done is seen) and busy count.
  task automatic run_mul(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [WIDTH-1:0] im, output int lat, output int busy_cnt,
                         output logic [WIDTH-1:0] res);
    a = ia; b = ib; m = im;
    start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    if (busy) busy_cnt++;
    while (!done && lat < MAX_CYC) begin
      if (poke_start && lat == 4) start = 1'b1;
      if (poke_start && lat == 5) start = 1'b0;
      if (scramble) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); m = WIDTH'($urandom);
      end
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    res = result;
  endtask

  task automatic directed(input string tag, input int unsigned ia, input int unsigned ib,
                          input int unsigned im);
    int lat, bc;
    logic [WIDTH-1:0] res;
    exp_q.push_back(ref_mont(ia, ib, im));
    run_mul(WIDTH'(ia), WIDTH'(ib), WIDTH'(im), lat, bc, res);
    check_val({tag, "_latency"}, lat, LAT);
    check_val({tag, "_busy_cycles"}, bc, BUSY_N);
    check_val({tag, "_result"}, res, exp_q.pop_front());
    @(negedge clk);
    check_val({tag, "_done_one_cycle"}, done, 0);
    check_val({tag, "_result_held"}, result, res);
  endtask

  initial begin
    int lat, bc, gap;
    int unsigned ra, rb, rm;
    logic [WIDTH-1:0] res;
    logic [31:0] e;
    bit seen_done;

    total = 0; bad = 0;
    poke_start = 0; scramble = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
    repeat (3) @(negedge clk);
    check_val("reset_result", result, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    directed("basic_13_5_7", 5, 7, 13);
    check_val("basic_known_value", result, 10);
    directed("ident_1019", 5, 5, 1019);
    check_val("ident_1019_known", result, 5);
    directed("ident_13", 1, 1, 13);
    check_val("ident_13_known", result, 4);
    directed("wide_1023", 1022, 1022, 1023);
    check_val("wide_1023_known", result, 1);
    directed("zero_a", 0, 1022, 1023);

    // start pulsed during busy must be ignored
    poke_start = 1;
    directed("start_while_busy", 5, 7, 13);
    poke_start = 0;
    repeat (LAT + 2) @(negedge clk);
    check_val("start_while_busy_no_extra", dbg_state, 0);

    // operands changed during CALC
    scramble = 1;
    directed("scramble", 777, 901, 1021);
    scramble = 0;

    // back-to-back with start held high
    a = 10'd300; b = 10'd451; m = 10'd997;
    e = ref_mont(300, 451, 997);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < MAX_CYC);
      check_val("b2b_gap", gap, LAT);
      check_val("b2b_result", result, e);
    end
    start = 1'b0;
    @(negedge clk);

    // reset mid-operation
    a = 10'd123; b = 10'd456; m = 10'd789;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_result", result, 0);
    check_val("midrst_done", done, 0);
    seen_done = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_val("midrst_no_done", seen_done, 0);
    directed("after_rst", 123, 456, 789);

    // even modulus: only handshake/latency are defined
    run_mul(10'd7, 10'd9, 10'd12, lat, bc, res);
    check_val("even_m_latency", lat, LAT);
    @(negedge clk);
    check_val("even_m_idle", dbg_state, 0);

    // random regression
    for (int n = 0; n < N_RAND; n++) begin
      rm = $urandom_range(1, (1 << WIDTH) - 1) | 1;
      ra = $urandom_range(0, rm - 1);
      rb = $urandom_range(0, rm - 1);
      exp_q.push_back(ref_mont(ra, rb, rm));
      run_mul(WIDTH'(ra), WIDTH'(rb), WIDTH'(rm), lat, bc, res);
      check_val("rand_latency", lat, LAT);
      check_val("rand_result", res, exp_q.pop_front());
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
